// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Error bit positions let a status block pack the flags into one word.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int WORD_BYTES     = 4;

    localparam int ERR_MISALIGNED = 0;
    localparam int ERR_RANGE      = 1;
    localparam int ERR_BUSY       = 2;
    localparam int ERR_COUNT      = 3;

    // Byte offset from the window base; addresses below base wrap high.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Memory-stage port between the CPU (master) and the data memory (slave).
interface dmem_if;
    logic [31:0] data_addr;
    logic [31:0] mem_write_data;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        err_clear;
    logic [31:0] mem_read_data;
    logic        read_valid;
    logic        busy;
    logic        err_misaligned;
    logic        err_range;
    logic        err_busy;

    modport master (
        output data_addr, mem_write_data, mem_read_en, mem_write_en, err_clear,
        input  mem_read_data, read_valid, busy, err_misaligned, err_range, err_busy
    );

    modport slave (
        input  data_addr, mem_write_data, mem_read_en, mem_write_en, err_clear,
        output mem_read_data, read_valid, busy, err_misaligned, err_range, err_busy
    );
endinterface

// File: rtl/dmem_array.sv
// 1R1W word array with registered read; a same-address collision returns
// the old word. Storage carries no reset so it maps onto block RAM.
module dmem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-fill sweep after reset, address decode with
// sticky error flags, and a one-cycle registered load path.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clear_ptr_reg, clear_ptr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= CLEAR;
            clear_ptr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            clear_ptr_reg <= clear_ptr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clear_ptr_next = clear_ptr_reg;
        if (state_reg == CLEAR) begin
            clear_ptr_next = clear_ptr_reg + 1'b1;
            if (clear_ptr_reg == LAST_IDX) begin
                state_next = READY;
            end
        end
    end

    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_ready, req, bad_align, bad_range, legal;

    assign off       = word_offset(bus.data_addr, BASE_ADDR);
    // BASE_ADDR is word aligned, so the offset's low bits are the address's.
    assign bad_align = off[1:0] != 2'b00;
    assign bad_range = off[31:ADDR_WIDTH+2] != '0;
    assign legal     = !bad_align && !bad_range;
    assign idx       = off[ADDR_WIDTH+1:2];
    assign is_ready  = state_reg == READY;
    assign req       = bus.mem_read_en | bus.mem_write_en;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata, ram_rdata;

    assign ram_we    = !is_ready | (bus.mem_write_en & legal);
    assign ram_waddr = is_ready ? idx : clear_ptr_reg;
    assign ram_wdata = is_ready ? bus.mem_write_data : 32'h0;
    assign ram_re    = is_ready & bus.mem_read_en & legal;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    // The array read register only loads on a legal read, so it already
    // holds the last value; zero_sel_reg masks it after reset or a bad read.
    logic read_valid_reg, zero_sel_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_valid_reg <= 1'b0;
            zero_sel_reg   <= 1'b1;
        end else begin
            read_valid_reg <= is_ready & bus.mem_read_en;
            if (is_ready && bus.mem_read_en) begin
                zero_sel_reg <= !legal;
            end
        end
    end

    logic [ERR_COUNT-1:0] err_reg, err_next, err_set;

    assign err_set[ERR_MISALIGNED] = is_ready & req & bad_align;
    assign err_set[ERR_RANGE]      = is_ready & req & bad_range;
    assign err_set[ERR_BUSY]       = !is_ready & req;

    // A new error in the same cycle as err_clear leaves the flag set.
    generate
        for (genvar gi = 0; gi < ERR_COUNT; gi++) begin : g_err
            assign err_next[gi] = (err_reg[gi] & ~bus.err_clear) | err_set[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.mem_read_data  = zero_sel_reg ? 32'h0 : ram_rdata;
    assign bus.read_valid     = read_valid_reg;
    assign bus.busy           = !is_ready;
    assign bus.err_misaligned = err_reg[ERR_MISALIGNED];
    assign bus.err_range      = err_reg[ERR_RANGE];
    assign bus.err_busy       = err_reg[ERR_BUSY];
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array
// reference model of the memory port.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(
        .ADDR_WIDTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;
    logic        m_valid, m_mis, m_rng, m_bsy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit re, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit clr);
        bus.mem_read_en    = re;
        bus.mem_write_en   = we;
        bus.data_addr      = a;
        bus.mem_write_data = d;
        bus.err_clear      = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_rdata = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_rng   = 1'b0;
        m_bsy   = 1'b0;
    endtask

    // One READY-state request: apply, clock, update the model, compare all outputs.
    task automatic do_op(input string tag, input bit re, input bit we,
                         input logic [31:0] a, input logic [31:0] d, input bit clr);
        logic [31:0] off;
        bit          mis, rng;
        int          w;
        drive(re, we, a, d, clr);
        tick();
        idle();
        off = a - BASE;
        mis = (a % 4) != 0;
        rng = off >= 32'(4 * DEPTH);
        w   = int'(off / 4);
        m_valid = re;
        if (re) m_rdata = (!mis && !rng) ? m_mem[w] : 32'h0;
        if (we && !mis && !rng) m_mem[w] = d;
        m_mis = (m_mis && !clr) || ((re || we) && mis);
        m_rng = (m_rng && !clr) || ((re || we) && rng);
        m_bsy = m_bsy && !clr;
        check({tag, ".valid"}, 32'(bus.read_valid),     32'(m_valid));
        check({tag, ".rdata"}, bus.mem_read_data,       m_rdata);
        check({tag, ".emis"},  32'(bus.err_misaligned), 32'(m_mis));
        check({tag, ".erng"},  32'(bus.err_range),      32'(m_rng));
        check({tag, ".ebsy"},  32'(bus.err_busy),       32'(m_bsy));
        check({tag, ".busy"},  32'(bus.busy),           32'h0);
        $display("op %-8s re=%0b we=%0b addr=%08h wdata=%08h clr=%0b -> valid=%0b rdata=%08h err=%0b%0b%0b",
                 tag, re, we, a, d, clr, bus.read_valid, bus.mem_read_data,
                 bus.err_busy, bus.err_range, bus.err_misaligned);
    endtask

    // Count edges from reset release until busy drops, bounded.
    task automatic wait_sweep(input int start, output int n, output int valid_seen);
        n = start;
        valid_seen = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            tick();
            n++;
            if (bus.read_valid !== 1'b0) valid_seen++;
        end
    endtask

    initial begin
        int          n, vs, r, idx;
        logic [31:0] a;
        bit          re, we, clr;

        idle();
        model_reset();

        // Reset state while rst is held low
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",  32'(bus.busy),           32'h1);
        check("rst.rdata", bus.mem_read_data,       32'h0);
        check("rst.valid", 32'(bus.read_valid),     32'h0);
        check("rst.errs",  {29'h0, bus.err_busy, bus.err_range, bus.err_misaligned}, 32'h0);

        rst = 1'b1;
        wait_sweep(0, n, vs);
        check("sweep.len",   32'(n),        32'(DEPTH));
        check("sweep.valid", 32'(vs),       32'h0);
        check("sweep.busy",  32'(bus.busy), 32'h0);
        $display("sweep finished after %0d cycles", n);

        do_op("rd3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        check("rd3fc.data", bus.mem_read_data, 32'h0);
        do_op("hold", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        do_op("wr010", 1'b0, 1'b1, 32'h010, 32'hCAFEF00D, 1'b0);
        do_op("rd010", 1'b1, 1'b0, 32'h010, 32'h0, 1'b0);
        check("rd010.data", bus.mem_read_data, 32'hCAFEF00D);

        do_op("wr020", 1'b0, 1'b1, 32'h020, 32'h11111111, 1'b0);
        do_op("rbw020", 1'b1, 1'b1, 32'h020, 32'h22222222, 1'b0);
        check("rbw020.data", bus.mem_read_data, 32'h11111111);
        do_op("rd020", 1'b1, 1'b0, 32'h020, 32'h0, 1'b0);
        check("rd020.data", bus.mem_read_data, 32'h22222222);

        do_op("rd402", 1'b1, 1'b0, 32'h402, 32'h0, 1'b0);
        check("rd402.mis", 32'(bus.err_misaligned), 32'h1);
        check("rd402.rng", 32'(bus.err_range),      32'h1);
        check("rd402.data", bus.mem_read_data,      32'h0);
        do_op("wr400", 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0);
        do_op("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
        check("rd000.data", bus.mem_read_data, 32'h0);
        do_op("clr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("clr.flags", {30'h0, bus.err_range, bus.err_misaligned}, 32'h0);
        do_op("setwins", 1'b1, 1'b0, 32'h401, 32'h0, 1'b1);
        check("setwins.mis", 32'(bus.err_misaligned), 32'h1);
        do_op("wrFFC", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5, 1'b0);
        do_op("clr2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic, weighted toward a few words to force collisions
        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 99);
            idx = (r < 40) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            if (r < 75)      a = 32'(idx * 4);
            else if (r < 87) a = 32'(idx * 4) + 32'($urandom_range(1, 3));
            else if (r < 95) a = 32'h400 + 32'(idx * 4);
            else             a = 32'hFFFF_FFFC - 32'($urandom_range(0, 3));
            re  = ($urandom_range(0, 1) == 1);
            we  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 19) == 0);
            do_op("rand", re, we, a, $urandom, clr);
        end

        // Busy-time request must flag err_busy and not disturb the sweep
        do_op("wr000", 1'b0, 1'b1, 32'h000, 32'h12345678, 1'b0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        repeat (9) tick();
        drive(1'b1, 1'b1, 32'h000, 32'hA5A5A5A5, 1'b0);
        tick();
        idle();
        check("bsyreq.ebsy",  32'(bus.err_busy),   32'h1);
        check("bsyreq.valid", 32'(bus.read_valid), 32'h0);
        m_bsy = 1'b1;
        wait_sweep(10, n, vs);
        check("bsyreq.len",   32'(n),  32'(DEPTH));
        check("bsyreq.vseen", 32'(vs), 32'h0);
        do_op("rd000b", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
        check("rd000b.data", bus.mem_read_data, 32'h0);
        do_op("clr3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset lands while a read is in flight
        do_op("wr010b", 1'b0, 1'b1, 32'h010, 32'h5A5A5A5A, 1'b0);
        drive(1'b1, 1'b0, 32'h010, 32'h0, 1'b0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        check("midrst.valid", 32'(bus.read_valid), 32'h0);
        check("midrst.busy",  32'(bus.busy),       32'h1);
        check("midrst.rdata", bus.mem_read_data,   32'h0);
        tick();
        check("midrst.valid2", 32'(bus.read_valid), 32'h0);
        tick();
        rst = 1'b1;
        model_reset();
        wait_sweep(0, n, vs);
        check("midrst.len",   32'(n),  32'(DEPTH));
        check("midrst.vseen", 32'(vs), 32'h0);
        do_op("rd010c", 1'b1, 1'b0, 32'h010, 32'h0, 1'b0);
        check("rd010c.data", bus.mem_read_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's memory-stage port: data_addr, mem_write_data, mem_read_en, mem_write_en in; mem_read_data out.
- Word-organised storage with a registered, one-cycle read latency, so read data lands in step with the memory/writeback pipeline register.
- After reset, an internal sweep FSM zero-fills the array while `busy` holds the system off.
- Illegal accesses are flagged through sticky error bits.

Parameters:
- ADDR_WIDTH, 8, word-index bits; DEPTH = 2**ADDR_WIDTH words (256 by default).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_addr  in  32  byte address of the access.
- mem_write_data  in  32  store data.
- mem_read_en  in  1  load request, sampled each cycle.
- mem_write_en  in  1  store request, sampled each cycle.
- err_clear  in  1  synchronous clear of the sticky error flags.
- mem_read_data  out  32  registered load data.
- read_valid  out  1  one-cycle pulse: mem_read_data updated this cycle.
- busy  out  1  high while the zero-fill sweep runs.
- err_misaligned  out  1  sticky: request with data_addr[1:0] != 0.
- err_range  out  1  sticky: request outside [BASE_ADDR, BASE_ADDR + 4*DEPTH).
- err_busy  out  1  sticky: request made while busy.

Behaviour:
- Reset (rst low, asynchronous):
  - state=CLEAR, clear_ptr=0, busy=1.
  - mem_read_data=0, read_valid=0, all err_* = 0.
  - The array itself is not reset; the sweep clears it.
- CLEAR state:
  - Each cycle: mem[clear_ptr] <= 0, clear_ptr++.
  - The cycle that writes index DEPTH-1 transitions to READY.
  - busy is 1 for exactly DEPTH cycles after rst deasserts; it falls at the edge that ends the last clear write.
- Requests during CLEAR: no array access, read_valid stays 0, err_busy set.
- Decode (READY state):
  - off = data_addr - BASE_ADDR, computed as 32-bit unsigned; an address below BASE wraps to a large value and is caught by the range check.
  - Address is out of range if off >= 4*DEPTH; misaligned if data_addr[1:0] != 0.
  - Address is legal only if neither condition holds; idx = off[ADDR_WIDTH+1:2].
- Write: mem_write_en on a legal address commits mem[idx] <= mem_write_data at the edge. On an illegal address: no write, matching err flag set.
- Read: mem_read_en sampled at edge N.
  - At edge N+1, mem_read_data = mem[idx] and read_valid=1 for that cycle.
  - On an illegal address: mem_read_data=0, read_valid=1, err flag set.
- No read request: mem_read_data holds its last value, read_valid=0.
- Simultaneous read and write to the same idx: read returns the pre-write contents (read-before-write); the write still commits.
- Read the cycle after a write to the same idx returns the new data; no forwarding logic is required, since the write has already committed.
- Error flags:
  - A misaligned and out-of-range access sets both flags.
  - Flags clear only on reset or err_clear.
  - err_clear together with a new error in the same cycle: the flag ends set (set wins).
- Reset mid-sweep or mid-READY:
  - Immediate return to CLEAR with clear_ptr=0.
  - A read pending across the reset edge produces no read_valid.

Decomposition:
- Shared package dmem_pkg:
  - state enum {CLEAR, READY}.
  - WORD_BYTES=4 constant.
  - Error-flag bit positions, for bus-level status aggregation.
- One natural sub-module, dmem_array: 1R1W synchronous word array with registered read port, read-before-write on a same-address collision, no reset on storage.
- The FSM, address decode and error logic stay in dmem_responder.

Test Plan:
- Release rst, hold requests low → busy=1 for exactly 256 cycles, then 0. Read of 0x3FC then returns 0 with read_valid one cycle later.
- Write 0xCAFEF00D to 0x010, then read 0x010 the next cycle → mem_read_data=0xCAFEF00D and read_valid=1 on the edge after the read request; no error flags.
- Write 0x11111111 to 0x020; next cycle assert read and write to 0x020 with data 0x22222222 → read returns 0x11111111; a following read returns 0x22222222.
- Read 0x402 → err_misaligned=1, err_range=1, mem_read_data=0, read_valid=1. Write to 0x400 → no array change (read 0x000 still 0). Pulse err_clear → both flags 0.
- Assert mem_write_en at 0x000 on cycle 10 of the sweep → err_busy=1. Sweep still completes at cycle 256, and 0x000 reads 0.
- Drop rst mid-READY, one cycle after issuing a read → read_valid never pulses, busy=1, mem_read_data=0, sweep restarts from index 0.
